// File: rtl/diff_dec_pkg.sv
// rtl/diff_dec_pkg.sv - shared types and helpers for the differential frame decoder
// Purpose: FSM state type, default sync word, counter-width helper.
package diff_dec_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Bits needed to hold values 0..n-1; never less than 1 so counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/diff_dec_fifo.sv
// rtl/diff_dec_fifo.sv - synchronous output FIFO for decoded words
// Purpose: stores completed words, presents the head word combinationally.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write request and word
//   pop               read request (ignored when empty)
//   full, empty       occupancy flags
//   head              oldest word; holds its last value while empty
module diff_dec_fifo
  import diff_dec_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  last_head;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (!empty) last_head <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/diff_frame_decoder.sv
// rtl/diff_frame_decoder.sv - differential decode, sync hunt and frame deserialiser
// Purpose: undoes toggle encoding, locks on SYNC, emits FRAME_WORDS words per frame.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, enc_in    qualified encoded line bit
//   out_valid/out_data  FIFO head (MSB = first received bit), out_ready pops
//   frame_active        high while locked
//   sync_det            one-cycle pulse after a sync match
//   overflow            sticky, a completed word was dropped
module diff_frame_decoder
  import diff_dec_pkg::*;
#(
  parameter int                WORD_W      = 8,
  parameter logic [WORD_W-1:0] SYNC        = WORD_W'(SYNC_DEFAULT),
  parameter int                FRAME_WORDS = 4,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              enc_in,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_active,
  output logic              sync_det,
  output logic              overflow
);

  localparam int BW  = clog2(WORD_W);
  localparam int WCW = clog2(FRAME_WORDS + 1);

  state_t            state_q, state_d;
  logic              prev_enc;
  logic [WORD_W-1:0] sh_q, sh_d, sh_shift;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d, word_inc;
  logic              sync_det_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dec;

  assign dec      = enc_in ^ prev_enc;
  assign sh_shift = {sh_q[WORD_W-2:0], dec};
  assign word_inc = word_cnt_q + WCW'(1);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sync_det_d = 1'b0;
    push       = 1'b0;
    if (in_valid) begin
      sh_d = sh_shift;
      unique case (state_q)
        HUNT: begin
          // Sliding window: every new bit re-tests the last WORD_W bits.
          if (sh_shift == SYNC) begin
            state_d    = LOCKED;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            sync_det_d = 1'b1;
          end
        end
        LOCKED: begin
          if (bit_cnt_q == BW'(WORD_W - 1)) begin
            push       = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = word_inc;
            if (word_inc == WCW'(FRAME_WORDS)) begin
              state_d = HUNT;
              sh_d    = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      prev_enc   <= 1'b0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sync_det   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (in_valid) prev_enc <= enc_in;
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sync_det   <= sync_det_d;
      // Dropped words still advance the frame counters above.
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign pop          = out_valid && out_ready;
  assign out_valid    = !fifo_empty;
  assign frame_active = (state_q == LOCKED);

  diff_dec_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sh_shift),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

endmodule

// File: tb/tb_diff_frame_decoder.sv
// tb/tb_diff_frame_decoder.sv - self-checking bench for diff_frame_decoder
module tb_diff_frame_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       enc_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] ov, fa, sd, of;
  logic [7:0] od [2];

  always #5 clk = ~clk;

  // Instance 0: four-word frames; instance 1: five-word frames. Same line.
  diff_frame_decoder #(.WORD_W(8), .SYNC(8'hA5), .FRAME_WORDS(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .enc_in(enc_in),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .frame_active(fa[0]), .sync_det(sd[0]), .overflow(of[0]));

  diff_frame_decoder #(.WORD_W(8), .SYNC(8'hA5), .FRAME_WORDS(5), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .enc_in(enc_in),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .frame_active(fa[1]), .sync_det(sd[1]), .overflow(of[1]));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: frame-level view of each receiver.
  int         fw [2] = '{4, 5};
  bit         m_prev;
  int         m_win [2];
  bit         m_locked [2];
  int         m_acc [2];
  int         m_nb [2];
  int         m_nw [2];
  logic [7:0] m_q [2][4];
  int         m_cnt [2];
  bit         m_ovf [2];
  bit         m_sync [2];
  int         sync_seen [2];
  bit         enc_st;
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit dec;
    bit pop;
    bit pushw;
    int sz;
    logic [7:0] wv;
    dec = enc_in ^ m_prev;
    for (int i = 0; i < 2; i++) begin
      pop = (m_cnt[i] > 0) && out_ready;
      pushw = 1'b0;
      wv = '0;
      m_sync[i] = 1'b0;
      if (reset) begin
        m_win[i] = 0; m_locked[i] = 0; m_acc[i] = 0; m_nb[i] = 0;
        m_nw[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        continue;
      end
      if (in_valid) begin
        if (!m_locked[i]) begin
          m_win[i] = ((m_win[i] << 1) | int'(dec)) & 'hFF;
          if (m_win[i] == 'hA5) begin
            m_locked[i] = 1; m_nb[i] = 0; m_nw[i] = 0; m_acc[i] = 0; m_sync[i] = 1;
          end
        end else begin
          m_acc[i] = ((m_acc[i] << 1) | int'(dec)) & 'hFF;
          m_nb[i]++;
          if (m_nb[i] == 8) begin
            pushw = 1'b1;
            wv = 8'(m_acc[i]);
            m_nb[i] = 0;
            m_nw[i]++;
            if (m_nw[i] == fw[i]) begin
              m_locked[i] = 0;
              m_win[i] = 0;
            end
          end
        end
      end
      sz = m_cnt[i];
      if (pop) begin
        for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
        m_cnt[i]--;
      end
      if (pushw) begin
        if (sz == 4 && !pop) m_ovf[i] = 1'b1;
        else begin
          m_q[i][m_cnt[i]] = wv;
          m_cnt[i]++;
        end
      end
    end
    if (reset) m_prev = 1'b0;
    else if (in_valid) m_prev = enc_in;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_cnt[i] > 0));
      if (m_cnt[i] > 0) chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(m_q[i][0]));
      chk($sformatf("frame_active[%0d]", i), 32'(fa[i]), 32'(m_locked[i]));
      chk($sformatf("sync_det[%0d]", i), 32'(sd[i]), 32'(m_sync[i]));
      chk($sformatf("overflow[%0d]", i), 32'(of[i]), 32'(m_ovf[i]));
      if (sd[i] === 1'b1) sync_seen[i]++;
    end
  endtask

  task automatic step();
    if (ov[0] === 1'b1 && out_ready) rx0.push_back(od[0]);
    if (ov[1] === 1'b1 && out_ready) rx1.push_back(od[1]);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic line_bit(input bit d);
    in_valid = 1'b1;
    enc_in = enc_st ^ d;
    enc_st = enc_in;
    step();
  endtask

  task automatic raw(input bit e);
    in_valid = 1'b1;
    enc_in = e;
    enc_st = e;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      enc_in = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int k = 7; k >= 0; k--) begin
      while ($urandom_range(0, 99) < gap) idle(1);
      line_bit(b[k]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    enc_in = 1'($urandom_range(0, 1));
    enc_st = 1'b0;
    step();
    chk("reset out_data[0]", 32'(od[0]), 32'h0);
    chk("reset out_data[1]", 32'(od[1]), 32'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    sync_seen[0] = 0;
    sync_seen[1] = 0;
    rx0.delete();
    rx1.delete();
  endtask

  logic [7:0] exp2 [4] = '{8'h3C, 8'hF0, 8'h0F, 8'h81};
  logic [7:0] exp4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    // 1: reset, then raw line bits 1,1,0,0,1 while hunting.
    do_reset();
    out_ready = 1'b1;
    raw(1); raw(1); raw(0); raw(0); raw(1);
    chk("t1 no lock", 32'(fa[0]), 32'h0);

    // 2: sync then one frame, consumer always ready.
    send_byte(8'hA5, 0);
    foreach (exp2[k]) send_byte(exp2[k], 0);
    idle(3);
    chk("t2 sync pulses", 32'(sync_seen[0]), 32'd1);
    chk("t2 word count", 32'(rx0.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx0.size(); k++) chk($sformatf("t2 word%0d", k), 32'(rx0[k]), 32'(exp2[k]));

    // 3: near-miss sync, then a real one.
    do_reset();
    out_ready = 1'b1;
    send_byte(8'hA4, 0);
    send_byte(8'h3C, 0);
    chk("t3 nothing stored", 32'(ov[0]), 32'h0);
    chk("t3 no sync", 32'(sync_seen[0]), 32'd0);
    send_byte(8'hA5, 0);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
    idle(3);
    chk("t3 sync pulses", 32'(sync_seen[0]), 32'd1);

    // 4: backpressure; five-word frame into a four-entry FIFO.
    do_reset();
    out_ready = 1'b0;
    send_byte(8'hA5, 0);
    foreach (exp4[k]) send_byte(exp4[k], 0);
    send_byte(8'h55, 0);
    chk("t4 overflow set", 32'(of[1]), 32'h1);
    rx1.delete();
    out_ready = 1'b1;
    idle(6);
    chk("t4 drained", 32'(rx1.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx1.size(); k++) chk($sformatf("t4 word%0d", k), 32'(rx1[k]), 32'(exp4[k]));
    chk("t4 overflow sticky", 32'(of[1]), 32'h1);

    // 5a: random frames with gaps and random consumer stalls.
    do_reset();
    for (int f = 0; f < 6; f++) begin
      out_ready = 1'($urandom_range(0, 1));
      send_byte(8'hA5, 30);
      for (int k = 0; k < 5; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        send_byte(8'($urandom), 30);
      end
    end
    out_ready = 1'b1;
    idle(6);

    // 5b: full FIFO, pop coincides with the push edge.
    do_reset();
    out_ready = 1'b0;
    send_byte(8'hA5, 0);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 0);
    send_byte(8'hA5, 0);
    for (int k = 7; k >= 1; k--) line_bit(k == 2);
    out_ready = 1'b1;
    line_bit(1'b1);
    for (int k = 6; k <= 8; k++) send_byte(8'(k), 0);
    idle(8);
    chk("t5 no overflow", 32'(of[0]), 32'h0);
    chk("t5 drained", 32'(rx0.size()), 32'd8);
    for (int k = 0; k < 8 && k < rx0.size(); k++) chk($sformatf("t5 word%0d", k), 32'(rx0[k]), 32'(k + 1));

    // 6: reset mid-word, then a clean frame.
    do_reset();
    out_ready = 1'b1;
    send_byte(8'hA5, 0);
    line_bit(1); line_bit(0); line_bit(1);
    do_reset();
    chk("t6 unlocked", 32'(fa[0]), 32'h0);
    out_ready = 1'b1;
    send_byte(8'hA5, 0);
    foreach (exp2[k]) send_byte(exp2[k], 10);
    idle(3);
    chk("t6 word count", 32'(rx0.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx0.size(); k++) chk($sformatf("t6 word%0d", k), 32'(rx0[k]), 32'(exp2[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
